// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared types and helpers for the binary-to-BCD converter.
//   - state_t          : converter FSM states (IDLE, SHIFT, DONE)
//   - digit_t          : one packed BCD digit (4 bits)
//   - digits_for_width : decimal digits needed to show 2**width-1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  // Smallest digit count whose decimal range covers every WIDTH-bit value.
  function automatic int digits_for_width(input int width);
    longint max_val;
    longint limit;
    int     n;
    max_val = (longint'(1) << width) - 1;
    n       = 1;
    limit   = 10;
    while (limit <= max_val) begin
      n     = n + 1;
      limit = limit * 10;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3
//   Combinational double-dabble correction cell for one BCD digit.
//   Adds 3 when the digit is 5 or more, so that the following left shift
//   carries correctly into the next decimal digit.
//   Ports:
//     din  : digit before correction
//     dout : digit after correction
module bcd_add3
  import bcd_pkg::*;
(
  input  digit_t din,
  output digit_t dout
);

  always_comb begin
    dout = din;
    if (din >= digit_t'(5)) begin
      dout = din + digit_t'(3);
    end
  end

endmodule

// File: rtl/bcd_converter.sv
// bcd_converter
//   Sequential double-dabble binary-to-BCD converter. A conversion takes
//   WIDTH shift cycles plus one DONE cycle; the result and a one-cycle
//   valid pulse appear WIDTH+1 cycles after the accepting start edge.
//   Optional feature (macro BCD_CONVERTER_BLANK_EN): adds a leading-zero
//   blanking output, updated together with bcd.
//   Parameters:
//     WIDTH  : width of the binary input
//     DIGITS : number of BCD digits produced (10**DIGITS must exceed 2**WIDTH-1)
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous active-high reset
//     start : request a conversion of bin (accepted only when ready)
//     bin   : unsigned binary input, captured on the accepting edge
//     ready : high while idle
//     valid : one-cycle pulse when bcd holds a new result
//     bcd   : packed BCD result, digit 0 (units) in bits [3:0]
//     blank : (macro only) blank[i] set when digit i and all above are zero;
//             blank[0] is always 0
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
`ifdef BCD_CONVERTER_BLANK_EN
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
`else
  output logic [4*DIGITS-1:0]   bcd
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     shift_reg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     scratch_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 last_shift;
  logic [BCD_W+WIDTH-1:0] shifted;

  // One correction cell per digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  // The counter still holds WIDTH-1 during the final shift cycle.
  assign last_shift = (bit_cnt == CNT_W'(WIDTH - 1));
  assign shifted    = {scratch_adj, shift_reg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  // Datapath. bcd and valid are loaded on the edge that leaves DONE, so the
  // pulse and the new result become visible in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          {scratch, shift_reg} <= shifted;
          bit_cnt              <= bit_cnt + 1'b1;
        end
        DONE: begin
          bcd   <= scratch;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_CONVERTER_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] blank_next;
  logic              all_zero;

  // Walk from the top digit down; a digit is blanked only while every digit
  // above it is also zero. The units digit is never blanked.
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (scratch[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank <= BLANK_RST;
    end else if (state == DONE) begin
      blank <= blank_next;
    end
  end
`endif

endmodule
